// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: FSM state and operation
// encodings, word geometry, default widths and the alignment helper.
package mem_access_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  // A byte address is word aligned when its byte-offset bits are all zero.
  function automatic logic is_misaligned(input logic [BYTE_OFF_W-1:0] byte_off);
    return (byte_off != {BYTE_OFF_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; times the read latency of an access.
module mem_lat_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins, otherwise decrement and saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {WIDTH{1'b0}})) begin
      count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/mem_access_unit.sv
// Requester side of the unified instruction/data memory. Accepts one fetch or
// load/store in IDLE (data wins over fetch), drives the registered memory
// port, and captures read data into IR or MDR after READ_LAT cycles.
// Optional build macro ALIGN_CHECK_EN: misaligned requests are rejected with
// a done + align_err pulse instead of being issued to memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifetch_req,
  input  logic [31:0]       pc,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [31:0]       data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              ifetch_done,
  output logic              data_done,
  output logic              busy,
  output logic              align_err
);

  localparam int CNT_W = $clog2(READ_LAT) + 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              ifetch_done_q, ifetch_done_d;
  logic              data_done_q, data_done_d;
  logic              align_err_q, align_err_d;

  logic [31:0]       req_addr_s;
  logic              misalign_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;
  logic              unused_s;

  // The winning request's byte address; data has priority over fetch.
  assign req_addr_s = data_req ? data_addr : pc;

`ifdef ALIGN_CHECK_EN
  assign misalign_s = is_misaligned(req_addr_s[BYTE_OFF_W-1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Address bits above the word index are intentionally ignored (wrap).
  assign unused_s = ^{req_addr_s[31:ADDR_W+BYTE_OFF_W], req_addr_s[BYTE_OFF_W-1:0]};

  mem_lat_counter #(
    .WIDTH (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_s),
    .load_val_i (CNT_W'(READ_LAT - 1)),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state and datapath: accept in IDLE, complete in ACCESS on counter zero.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_d      = 1'b0;
    ir_d             = ir_q;
    mdr_d            = mdr_q;
    ifetch_done_d    = 1'b0;
    data_done_d      = 1'b0;
    align_err_d      = 1'b0;
    cnt_load_s       = 1'b0;
    cnt_dec_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_req || ifetch_req) begin
          op_d = data_req ? (data_we ? OP_STORE : OP_LOAD) : OP_FETCH;
          if (misalign_s) begin
            align_err_d   = 1'b1;
            data_done_d   = data_req;
            ifetch_done_d = !data_req;
          end else begin
            mem_address_d = req_addr_s[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
            if (data_req && data_we) begin
              mem_write_data_d = data_wdata;
              mem_write_d      = 1'b1;
            end else begin
              mem_write_data_d = mem_write_data_q;
            end
            cnt_load_s = 1'b1;
            state_d    = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_dec_s = 1'b1;
        if (cnt_zero_s) begin
          case (op_q)
            OP_FETCH: begin
              ir_d          = mem_read_data;
              ifetch_done_d = 1'b1;
            end
            OP_LOAD: begin
              mdr_d       = mem_read_data;
              data_done_d = 1'b1;
            end
            OP_STORE: begin
              data_done_d = 1'b1;
            end
            default: begin
              data_done_d = 1'b0;
            end
          endcase
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      op_q             <= OP_FETCH;
      mem_address_q    <= {ADDR_W{1'b0}};
      mem_write_data_q <= {DATA_W{1'b0}};
      mem_write_q      <= 1'b0;
      ir_q             <= {DATA_W{1'b0}};
      mdr_q            <= {DATA_W{1'b0}};
      ifetch_done_q    <= 1'b0;
      data_done_q      <= 1'b0;
      align_err_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q      <= mem_write_d;
      ir_q             <= ir_d;
      mdr_q            <= mdr_d;
      ifetch_done_q    <= ifetch_done_d;
      data_done_q      <= data_done_d;
      align_err_q      <= align_err_d;
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign ir             = ir_q;
  assign mdr            = mdr_q;
  assign ifetch_done    = ifetch_done_q;
  assign data_done      = data_done_q;
  assign busy           = (state_q == ST_ACCESS);
  assign align_err      = align_err_q;

endmodule
